twos_comp_seq_divider: RTL



---
 rtl/twos_comp_seq_divider_pkg.sv | 39 +++
 rtl/twos_comp_seq_divider_if.sv | 33 +++
 rtl/twos_comp_seq_divider_nr_addsub_step.sv | 31 +++
 rtl/twos_comp_seq_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/twos_comp_seq_divider_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : twos_comp_seq_divider_pkg                                  |
// | Purpose : Shared state encodings, default width and sign helpers     |
// |           for the sequential two's complement divider.               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package twos_comp_seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Helpers work on a wide container; callers zero-extend into it and
  // keep only their own low bits of the result.
  localparam int MAX_W = 64;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RUN  = 2'd1;
  localparam logic [1:0] ENC_FIX  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_RUN  = ENC_RUN,
    ST_FIX  = ENC_FIX
  } state_t;

  // Two's complement negation; low bits are correct for any narrower width.
  function automatic logic [MAX_W-1:0] neg_val(input logic [MAX_W-1:0] v);
    return -v;
  endfunction

  // Magnitude of a value whose sign bit is supplied separately by the caller.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                               input logic         is_neg);
    return is_neg ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/twos_comp_seq_divider_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : twos_comp_seq_divider_if                                   |
// | Purpose : Start/done request bus of the sequential divider.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface twos_comp_seq_divider_if
  import twos_comp_seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/twos_comp_seq_divider_nr_addsub_step.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nr_addsub_step                                             |
// | Purpose : One non-restoring iteration: WIDTH+1-bit add or subtract   |
// |           of the divisor magnitude, plus the resulting quotient bit. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module nr_addsub_step
  import twos_comp_seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic [WIDTH:0]   i_p,     // partial remainder (already shifted)
  input  wire logic [WIDTH-1:0] i_d,     // divisor magnitude
  input  wire logic             i_m,     // 1 = subtract, 0 = add
  output logic      [WIDTH:0]   o_p,
  output logic                  o_qbit
);
  logic [WIDTH:0] w_d_ext;

  assign w_d_ext = {1'b0, i_d};

  // Single adder/subtractor shared by every iteration and the final restore.
  assign o_p    = i_m ? (i_p - w_d_ext) : (i_p + w_d_ext);

  // Non-negative result means the trial step "fit": quotient bit is 1.
  assign o_qbit = ~o_p[WIDTH];

endmodule
`default_nettype wire

// File: rtl/twos_comp_seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : twos_comp_seq_divider                                      |
// | Purpose : Signed sequential non-restoring divider, WIDTH+2 edges     |
// |           from accepted start to done; truncating quotient,          |
// |           remainder follows the dividend sign.                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module twos_comp_seq_divider
  import twos_comp_seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input wire logic                 clk,
  input wire logic                 rst,
  twos_comp_seq_divider_if.slave   bus
);
  localparam int               CW        = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] C_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_iter;
  logic             w_finish;

  logic [WIDTH:0]   r_p;        // signed partial remainder
  logic [WIDTH-1:0] r_q;        // dividend magnitude shifting out, quotient in
  logic [WIDTH-1:0] r_d;        // divisor magnitude
  logic [WIDTH-1:0] r_dvd;      // raw dividend (sign, div-by-zero remainder)
  logic             r_dvs_neg;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_done;
  logic             r_dz;
  logic             r_ov;

  logic [WIDTH:0]   w_step_p_in;
  logic             w_step_m;
  logic [WIDTH:0]   w_step_p_out;
  logic             w_step_qbit;

  logic [MAX_W-1:0] w_abs_dvd_ext;
  logic [MAX_W-1:0] w_abs_dvs_ext;
  logic [MAX_W-1:0] w_q_neg_ext;
  logic [MAX_W-1:0] w_r_neg_ext;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_dvd_neg;
  logic             w_dz;
  logic             w_ov;
  logic             w_unused;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_iter   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_iter = 1'b1;
        if (r_cnt == '0) w_next = ST_FIX;
      end
      ST_FIX: begin
        w_finish = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand magnitudes captured at start.
  assign w_abs_dvd_ext = abs_val(MAX_W'(bus.dividend), bus.dividend[WIDTH-1]);
  assign w_abs_dvs_ext = abs_val(MAX_W'(bus.divisor),  bus.divisor[WIDTH-1]);

  // In RUN the step sees {P,Q} shifted left and the mode follows the sign of
  // P; in FIX the same step is reused as a plain add to restore a negative P.
  assign w_step_p_in = (r_state == ST_FIX) ? r_p  : {r_p[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_step_m    = (r_state == ST_FIX) ? 1'b0 : ~r_p[WIDTH];

  nr_addsub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_p    (w_step_p_in),
    .i_d    (r_d),
    .i_m    (w_step_m),
    .o_p    (w_step_p_out),
    .o_qbit (w_step_qbit)
  );

  // Restored remainder is in [0, |divisor|) and so fits in WIDTH bits.
  assign w_rem_mag   = r_p[WIDTH] ? w_step_p_out[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_q_neg_ext = neg_val(MAX_W'(r_q));
  assign w_r_neg_ext = neg_val(MAX_W'(w_rem_mag));
  assign w_dvd_neg   = r_dvd[WIDTH-1];

  assign w_quot_fix  = (w_dvd_neg ^ r_dvs_neg) ? w_q_neg_ext[WIDTH-1:0] : r_q;
  assign w_rem_fix   = w_dvd_neg ? w_r_neg_ext[WIDTH-1:0] : w_rem_mag;

  // Status: zero divisor, and the single quotient that does not fit (MIN / -1).
  assign w_dz = (r_d == '0);
  assign w_ov = r_dvs_neg && (r_d == WIDTH'(1)) && (r_dvd == C_INT_MIN);

  // Iteration datapath: load on accept, shift/step once per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p       <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_dvd     <= '0;
      r_dvs_neg <= 1'b0;
      r_cnt     <= '0;
    end else if (w_load) begin
      r_p       <= '0;
      r_q       <= w_abs_dvd_ext[WIDTH-1:0];
      r_d       <= w_abs_dvs_ext[WIDTH-1:0];
      r_dvd     <= bus.dividend;
      r_dvs_neg <= bus.divisor[WIDTH-1];
      r_cnt     <= CW'(WIDTH-1);
    end else if (w_iter) begin
      r_p       <= w_step_p_out;
      r_q       <= {r_q[WIDTH-2:0], w_step_qbit};
      r_cnt     <= r_cnt - CW'(1);
    end
  end

  // Result registers: updated only on completion, held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_ov   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_quot <= w_dz ? '1    : w_quot_fix;
        r_rem  <= w_dz ? r_dvd : w_rem_fix;
        r_dz   <= w_dz;
        r_ov   <= w_ov;
      end
    end
  end

  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz;
  assign bus.overflow    = r_ov;

  // Upper bits of the wide helper results carry no information here.
  assign w_unused = ^{w_abs_dvd_ext[MAX_W-1:WIDTH], w_abs_dvs_ext[MAX_W-1:WIDTH],
                      w_q_neg_ext[MAX_W-1:WIDTH],   w_r_neg_ext[MAX_W-1:WIDTH]};

endmodule
`default_nettype wire
